// File: rtl/wb_interconnect_decode.sv
// wb_interconnect_decode: routes one Wishbone classic initiator to one of N targets by address match
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   i_adr/i_dat_w/i_we/i_sel/i_cyc/i_stb   initiator request
//   i_dat_r/i_ack/i_err                    initiator response
//   t_adr/t_dat_w/t_we/t_sel               request broadcast to every target
//   t_cyc/t_stb                            per-target cycle/strobe, one-hot or zero
//   t_dat_r/t_ack/t_err                    per-target response, flattened
module wb_interconnect_decode #(
  parameter int N_TARGETS = 2,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter logic [N_TARGETS*ADR_W-1:0] T_ADR_BASE = '0,
  parameter logic [N_TARGETS*ADR_W-1:0] T_ADR_MASK = '0,
  parameter int TIMEOUT = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADR_W-1:0]           i_adr,
  input  logic [DAT_W-1:0]           i_dat_w,
  output logic [DAT_W-1:0]           i_dat_r,
  input  logic                       i_cyc,
  input  logic                       i_stb,
  input  logic                       i_we,
  input  logic [DAT_W/8-1:0]         i_sel,
  output logic                       i_ack,
  output logic                       i_err,
  output logic [ADR_W-1:0]           t_adr,
  output logic [DAT_W-1:0]           t_dat_w,
  output logic                       t_we,
  output logic [DAT_W/8-1:0]         t_sel,
  input  logic [N_TARGETS*DAT_W-1:0] t_dat_r,
  output logic [N_TARGETS-1:0]       t_cyc,
  output logic [N_TARGETS-1:0]       t_stb,
  input  logic [N_TARGETS-1:0]       t_ack,
  input  logic [N_TARGETS-1:0]       t_err
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR = 2'd2;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [N_TARGETS-1:0] ONE = 1;
  logic [1:0] state;
  logic [N_TARGETS-1:0] sel_q, hit;
  logic [CW-1:0] to_cnt;
  logic [DAT_W-1:0] dat;
  logic active, req, ack_sel, err_sel, to_exp;
  assign t_adr = i_adr;
  assign t_dat_w = i_dat_w;
  assign t_we = i_we;
  assign t_sel = i_sel;
  assign active = state == ST_ACTIVE;
  assign req = i_cyc & i_stb;
  assign ack_sel = |(t_ack & sel_q);
  assign err_sel = |(t_err & sel_q);
  assign to_exp = TIMEOUT > 0 && to_cnt == TO_LAST;
  assign t_cyc = active ? sel_q & {N_TARGETS{req}} : '0;
  assign t_stb = t_cyc;
  assign i_ack = active & ack_sel;
  // a coinciding ack suppresses the timeout error; a target error always passes
  assign i_err = (state == ST_ERR) | (active & (err_sel | (to_exp & ~ack_sel)));
  assign i_dat_r = active ? dat : '0;
  // descending scan so the lowest matching index is written last and wins
  always_comb begin
    hit = '0;
    for (int k = N_TARGETS - 1; k >= 0; k--)
      if ((i_adr & T_ADR_MASK[k*ADR_W +: ADR_W]) == (T_ADR_BASE[k*ADR_W +: ADR_W] & T_ADR_MASK[k*ADR_W +: ADR_W])) hit = ONE << k;
  end
  always_comb begin
    dat = '0;
    for (int k = 0; k < N_TARGETS; k++) dat = dat | (sel_q[k] ? t_dat_r[k*DAT_W +: DAT_W] : '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      sel_q <= '0;
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (req) begin
        state <= |hit ? ST_ACTIVE : ST_ERR;
        sel_q <= |hit ? hit : sel_q;
        to_cnt <= '0;
      end
    end else if (active) begin
      to_cnt <= to_cnt + 1'b1;
      if (i_ack | i_err | ~i_cyc) state <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_wb_interconnect_decode.sv
// tb_wb_interconnect_decode: directed self-checking bench for wb_interconnect_decode
module tb_wb_interconnect_decode;
  logic clock = 0, reset = 1;
  logic [31:0] i_adr = 0, i_dat_w = 0, i_dat_r, t_adr, t_dat_w;
  logic i_cyc = 0, i_stb = 0, i_we = 0, i_ack, i_err, t_we;
  logic [3:0] i_sel = 0, t_sel;
  logic [63:0] t_dat_r = {32'hCAFEF00D, 32'hDEADBEEF};
  logic [1:0] t_cyc, t_stb, t_ack = 0, t_err = 0;
  int checks = 0, errors = 0;

  wb_interconnect_decode #(
    .N_TARGETS(2), .ADR_W(32), .DAT_W(32),
    .T_ADR_BASE({32'h1000_0000, 32'h0000_0000}),
    .T_ADR_MASK({32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_ack(i_ack), .i_err(i_err),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_we(t_we), .t_sel(t_sel), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_ack(t_ack), .t_err(t_err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we);
    i_adr = adr; i_we = we; i_cyc = 1; i_stb = 1;
  endtask

  task automatic idle;
    i_cyc = 0; i_stb = 0; i_we = 0; t_ack = 0; t_err = 0;
  endtask

  task automatic test_reset;
    cyc; cyc; reset = 0;
    #1;
    checks++; if (t_cyc !== 2'b00) begin errors++; $display("FAIL rst_cyc got %b exp 00", t_cyc); end
    checks++; if (i_ack !== 1'b0 || i_err !== 1'b0) begin errors++; $display("FAIL rst_term got ack=%b err=%b exp 0 0", i_ack, i_err); end
    checks++; if (i_dat_r !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", i_dat_r); end
  endtask

  task automatic test_read_t1;
    cyc; req(32'h1000_0004, 0);
    #1;
    checks++; if (t_stb !== 2'b00) begin errors++; $display("FAIL rd_decode_stb got %b exp 00", t_stb); end
    cyc; t_ack = 2'b10;
    #1;
    checks++; if (t_stb !== 2'b10 || t_cyc !== 2'b10) begin errors++; $display("FAIL rd_stb got stb=%b cyc=%b exp 10", t_stb, t_cyc); end
    checks++; if (i_ack !== 1'b1 || i_err !== 1'b0) begin errors++; $display("FAIL rd_ack got ack=%b err=%b exp 1 0", i_ack, i_err); end
    checks++; if (i_dat_r !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_dat got %h exp cafef00d", i_dat_r); end
    cyc; idle;
    #1;
    checks++; if (t_stb !== 2'b00 || i_ack !== 1'b0 || i_dat_r !== 32'h0) begin errors++; $display("FAIL rd_end got stb=%b ack=%b dat=%h exp 00 0 0", t_stb, i_ack, i_dat_r); end
  endtask

  task automatic test_write_t0;
    int acks = 0;
    cyc; req(32'h0000_0010, 1); i_dat_w = 32'h12345678; i_sel = 4'hF;
    #1;
    checks++; if (t_dat_w !== 32'h12345678 || t_we !== 1'b1 || t_sel !== 4'hF || t_adr !== 32'h10) begin errors++; $display("FAIL wr_bcast got adr=%h dat=%h we=%b sel=%h", t_adr, t_dat_w, t_we, t_sel); end
    for (int i = 0; i < 4; i++) begin
      cyc; t_ack = i == 3 ? 2'b01 : 2'b00;
      #1;
      acks += int'(i_ack);
      checks++; if (t_stb !== 2'b01) begin errors++; $display("FAIL wr_stb cycle %0d got %b exp 01", i, t_stb); end
    end
    checks++; if (acks != 1 || i_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %0d pulses last=%b exp 1 1", acks, i_ack); end
    cyc; idle;
    #1;
    checks++; if (t_stb !== 2'b00 || i_ack !== 1'b0) begin errors++; $display("FAIL wr_end got stb=%b ack=%b exp 00 0", t_stb, i_ack); end
  endtask

  task automatic test_unmapped;
    cyc; req(32'h2000_0000, 0);
    #1;
    checks++; if (t_cyc !== 2'b00 || i_err !== 1'b0) begin errors++; $display("FAIL um_decode got cyc=%b err=%b exp 00 0", t_cyc, i_err); end
    cyc; idle;
    #1;
    checks++; if (i_err !== 1'b1 || i_ack !== 1'b0 || t_cyc !== 2'b00) begin errors++; $display("FAIL um_err got err=%b ack=%b cyc=%b exp 1 0 00", i_err, i_ack, t_cyc); end
    cyc;
    #1;
    checks++; if (i_err !== 1'b0 || t_cyc !== 2'b00) begin errors++; $display("FAIL um_after got err=%b cyc=%b exp 0 00", i_err, t_cyc); end
  endtask

  task automatic test_timeout(input logic ack_last);
    cyc; req(32'h1000_0000, 0);
    for (int i = 0; i < 8; i++) begin
      cyc; t_ack = (ack_last && i == 7) ? 2'b10 : 2'b00;
      #1;
      checks++; if (t_stb !== 2'b10) begin errors++; $display("FAIL to_stb cycle %0d got %b exp 10", i, t_stb); end
      checks++; if (i_err !== (i == 7 && !ack_last) || i_ack !== (i == 7 && ack_last)) begin errors++; $display("FAIL to_term cycle %0d ack_last=%b got ack=%b err=%b", i, ack_last, i_ack, i_err); end
    end
    cyc; t_ack = 0;
    #1;
    checks++; if (t_stb !== 2'b00 || i_err !== 1'b0) begin errors++; $display("FAIL to_drop got stb=%b err=%b exp 00 0", t_stb, i_err); end
    idle;
  endtask

  task automatic test_target_err;
    cyc; req(32'h0000_0000, 0);
    cyc; t_err = 2'b01; t_ack = 2'b10;
    #1;
    checks++; if (i_err !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("FAIL terr got ack=%b err=%b exp 0 1", i_ack, i_err); end
    checks++; if (i_dat_r !== 32'hDEADBEEF) begin errors++; $display("FAIL terr_dat got %h exp deadbeef", i_dat_r); end
    cyc; idle;
    #1;
    checks++; if (t_stb !== 2'b00 || i_err !== 1'b0) begin errors++; $display("FAIL terr_end got stb=%b err=%b", t_stb, i_err); end
  endtask

  task automatic test_back_to_back;
    cyc; req(32'h0000_0000, 0);
    cyc; t_ack = 2'b01;
    #1;
    checks++; if (t_stb !== 2'b01 || i_ack !== 1'b1) begin errors++; $display("FAIL b2b_first got stb=%b ack=%b exp 01 1", t_stb, i_ack); end
    cyc; t_ack = 0; i_adr = 32'h1000_0000;
    #1;
    checks++; if (t_stb !== 2'b00 || i_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got stb=%b ack=%b exp 00 0", t_stb, i_ack); end
    cyc; t_ack = 2'b10;
    #1;
    checks++; if (t_stb !== 2'b10 || i_ack !== 1'b1 || i_dat_r !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_second got stb=%b ack=%b dat=%h", t_stb, i_ack, i_dat_r); end
    cyc; idle;
    #1;
    checks++; if (t_stb !== 2'b00) begin errors++; $display("FAIL b2b_end got stb=%b exp 00", t_stb); end
  endtask

  task automatic test_abort;
    cyc; req(32'h0000_0000, 0);
    cyc;
    #1;
    checks++; if (t_stb !== 2'b01) begin errors++; $display("FAIL ab_stb got %b exp 01", t_stb); end
    cyc; i_cyc = 0;
    #1;
    checks++; if (t_cyc !== 2'b00 || t_stb !== 2'b00 || i_ack !== 1'b0 || i_err !== 1'b0) begin errors++; $display("FAIL ab_gate got cyc=%b stb=%b ack=%b err=%b", t_cyc, t_stb, i_ack, i_err); end
    cyc; idle;
    #1;
    checks++; if (t_cyc !== 2'b00 || i_err !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("FAIL ab_after got cyc=%b ack=%b err=%b", t_cyc, i_ack, i_err); end
  endtask

  task automatic test_reset_mid;
    cyc; req(32'h1000_0000, 0);
    cyc;
    #1;
    checks++; if (t_stb !== 2'b10) begin errors++; $display("FAIL rm_stb got %b exp 10", t_stb); end
    reset = 1;
    cyc;
    #1;
    checks++; if (t_cyc !== 2'b00 || i_ack !== 1'b0 || i_err !== 1'b0 || i_dat_r !== 32'h0) begin errors++; $display("FAIL rm_clear got cyc=%b ack=%b err=%b dat=%h", t_cyc, i_ack, i_err, i_dat_r); end
    reset = 0;
    cyc; t_ack = 2'b10;
    #1;
    checks++; if (t_stb !== 2'b10 || i_ack !== 1'b1 || i_dat_r !== 32'hCAFEF00D) begin errors++; $display("FAIL rm_next got stb=%b ack=%b dat=%h", t_stb, i_ack, i_dat_r); end
    cyc; idle;
    #1;
    checks++; if (t_stb !== 2'b00 || i_ack !== 1'b0) begin errors++; $display("FAIL rm_end got stb=%b ack=%b", t_stb, i_ack); end
  endtask

  initial begin
    test_reset;
    test_read_t1;
    test_write_t0;
    test_unmapped;
    test_timeout(0);
    test_timeout(1);
    test_target_err;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_interconnect_decode.md
# wb_interconnect_decode

Single-initiator to N-target Wishbone (classic, non-pipelined) address decoder and router. It sits on the target side of the interconnect, after the initiator arbiter, and steers the granted initiator's cycle to exactly one target chosen by address. Unmapped addresses and non-responding targets are terminated with a one-cycle error, so the initiator never hangs.

## Interface
- N_TARGETS, 2, number of target ports (>=1)
- ADR_W, 32, address width
- DAT_W, 32, data width; sel width is DAT_W/8
- T_ADR_BASE, 0, N_TARGETS*ADR_W flattened; slice k is the base of target k
- T_ADR_MASK, 0, N_TARGETS*ADR_W flattened; slice k is the compare mask of target k
- TIMEOUT, 256, cycles allowed in ACTIVE before a forced error; 0 disables the timeout

- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- i_adr  in  ADR_W  initiator address
- i_dat_w  in  DAT_W  initiator write data
- i_dat_r  out  DAT_W  read data returned to the initiator
- i_cyc, i_stb, i_we  in  1  initiator cycle, strobe and write enable
- i_sel  in  DAT_W/8  byte selects
- i_ack, i_err  out  1  termination to the initiator
- t_adr  out  ADR_W  i_adr, broadcast to all targets
- t_dat_w  out  DAT_W  i_dat_w, broadcast
- t_we  out  1  i_we, broadcast
- t_sel  out  DAT_W/8  i_sel, broadcast
- t_dat_r  in  N_TARGETS*DAT_W  per-target read data, flattened
- t_cyc, t_stb  out  N_TARGETS  per-target cycle and strobe; at most one bit set
- t_ack, t_err  in  N_TARGETS  per-target terminations

## Operation
- Address match for target k: (i_adr & mask_k) == (base_k & mask_k). If ranges overlap, the lowest matching index wins.
- States are IDLE, ACTIVE and ERR. Registers are state, sel_q (a one-hot vector of N_TARGETS bits) and to_cnt.
- **IDLE**
  - All t_cyc and t_stb are 0, and i_ack and i_err are 0.
  - If i_cyc & i_stb and some target matches: latch the one-hot sel_q, clear to_cnt, go to ACTIVE.
  - If i_cyc & i_stb and no target matches: go to ERR.
- **ACTIVE**
  - t_cyc = t_stb = sel_q & {N{i_cyc & i_stb}}.
  - i_ack = |(t_ack & sel_q).
  - i_err = |(t_err & sel_q), or the timeout has expired.
  - i_dat_r = the t_dat_r slice selected by sel_q (combinational).
  - t_ack and t_err of unselected targets are ignored.
- **ACTIVE exits**
  - On i_ack or i_err: go to IDLE.
  - If i_cyc drops (initiator abort): go to IDLE. t_cyc and t_stb are gated low in the same cycle.
- **Timeout** (TIMEOUT>0)
  - to_cnt increments once per ACTIVE cycle.
  - When to_cnt == TIMEOUT-1 and the selected target asserts neither ack nor err in that cycle, i_err is asserted for that cycle and the state goes to IDLE.
  - If ack and timeout coincide, ack wins: i_ack=1, i_err=0.
  - If the target asserts ack and err together, both pass through.
- **ERR**
  - i_err=1 for exactly one cycle. No target is strobed. Go to IDLE.
- i_dat_r is 0 outside ACTIVE.
- Reset: state=IDLE, sel_q=0, to_cnt=0. Therefore t_cyc, t_stb, i_ack, i_err and i_dat_r are all 0 from the first cycle after reset.
- Reset asserted mid-ACTIVE drops the target strobe on the following edge. No termination is generated.

## Timing
- Decode latency is 1 cycle: a request sampled in IDLE at edge n drives t_stb from cycle n+1.
- Target terminations pass combinationally to the initiator with zero added latency.
- The minimum transaction takes 2 cycles (IDLE decode, then ACTIVE with an immediate ack).
- Unmapped accesses: i_err is high in the cycle after the request is sampled.
- Back-to-back: after a termination, state is IDLE in the next cycle. A request still held or newly presented there is decoded again, so successive accesses are at least 2 cycles apart.
- Timeout: worst case, i_err appears TIMEOUT cycles after t_stb first rises.

## Test plan
Setup for all tests: N_TARGETS=2, base0=0x0000_0000, base1=0x1000_0000, both masks 0xF000_0000, TIMEOUT=8.
- **Read, target 1:** read 0x1000_0004 with t1 acking on its first strobe cycle and t_dat_r[1]=0xCAFEF00D -> t_stb=2'b10 for 1 cycle, i_ack=1 with i_dat_r=0xCAFEF00D; t0 never strobed.
- **Write, target 0:** write 0x0000_0010, data 0x12345678, sel 4'hF, t0 acks after 3 wait cycles -> t_dat_w=0x12345678, t_we=1, t_stb[0] high for 4 cycles, single i_ack pulse.
- **Unmapped:** access 0x2000_0000 -> i_err=1 for exactly one cycle, t_cyc=0 throughout, i_ack=0.
- **Timeout:** t1 never responds -> i_err on the 8th ACTIVE cycle, t_stb[1] drops the next cycle. Variant: t1 acks in the 8th cycle -> i_ack=1, i_err=0.
- **Back-to-back and abort:**
  - t0 access then t1 access with ack on the first strobe each -> strobes 1 cycle each, separated by one IDLE cycle.
  - i_cyc dropped while ACTIVE -> t_cyc low in the same cycle, no termination.
- **Reset mid-cycle:** reset asserted during ACTIVE -> all outputs 0 on the next edge. A following access to 0x1000_0000 completes normally.
